clint_arbiter: RTL

CLINT_ARBITER -- requirements
Module: clint_arbiter

---
 rtl/clint_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/clint_arbiter.sv
// Two-requester round-robin arbiter in front of the CLINT timer block.
// Each access takes three cycles: latch (IDLE), slave strobe (ACCESS), ack (RESP).
module clint_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_m0_req,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    output logic          o_m0_ack,
    output logic [DW-1:0] o_m0_rdata,
    input  logic          i_m1_req,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    output logic          o_m1_ack,
    output logic [DW-1:0] o_m1_rdata,
    output logic          o_s_wen,
    output logic          o_s_ren,
    output logic [AW-1:0] o_s_addr,
    output logic [DW-1:0] o_s_wrdata,
    input  logic [DW-1:0] i_s_rddata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_win;
    logic          r_we;
    logic          r_last;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    logic          w_grant1;
    logic          w_latch;
    logic          w_wen;
    logic          w_ren;
    logic          w_ack0;
    logic          w_ack1;

    // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
    assign w_grant1 = i_m1_req & (~i_m0_req | ~r_last);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_wen        = 1'b0;
        w_ren        = 1'b0;
        w_ack0       = 1'b0;
        w_ack1       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_m0_req || i_m1_req) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_wen        = r_we;
                w_ren        = ~r_we;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_ack0       = ~r_win;
                w_ack1       = r_win;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_win      <= 1'b0;
            r_we       <= 1'b0;
            r_last     <= 1'b1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            if (w_latch) begin
                r_win   <= w_grant1;
                r_we    <= w_grant1 ? i_m1_we    : i_m0_we;
                r_addr  <= w_grant1 ? i_m1_addr  : i_m0_addr;
                r_wdata <= w_grant1 ? i_m1_wdata : i_m0_wdata;
            end
            // Writes return zero so a stale read value never masquerades as write data.
            if (w_wen || w_ren) begin
                if (r_win) begin
                    r_m1_rdata <= r_we ? '0 : i_s_rddata;
                end else begin
                    r_m0_rdata <= r_we ? '0 : i_s_rddata;
                end
            end
            if (w_ack0 || w_ack1) begin
                r_last <= r_win;
            end
        end
    end

    assign o_m0_ack   = w_ack0;
    assign o_m1_ack   = w_ack1;
    assign o_m0_rdata = r_m0_rdata;
    assign o_m1_rdata = r_m1_rdata;
    assign o_s_wen    = w_wen;
    assign o_s_ren    = w_ren;
    assign o_s_addr   = r_addr;
    assign o_s_wrdata = r_wdata;

endmodule
